// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide sequencer owning the HI/LO pair.
//
// Accepts MULT/MULTU/DIV/DIVU (32-cycle radix-2 shift-add multiply or
// restoring divide, then a 1-cycle sign fix-up) and MTHI/MTLO (written on
// the issuing edge). Results land in HI/LO at the end of the FIX cycle.
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let a multiply leave CALC
// as soon as the remaining multiplier bits are all zero.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start, op     issue strobe and opcode from EX
//                 (000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO)
//   a, b          rs / rt operands
//   flush         aborts the in-flight op; suppresses a same-cycle issue
//   hilo_rd       MFHI/MFLO in EX this cycle
//   busy          computation in flight (CALC or FIX)
//   done          one-cycle pulse after HI/LO take a MULT/DIV result
//   stall         busy & (hilo_rd | start)
//   hi, lo        HI / LO registers
//   state_dbg     current FSM state (0 IDLE, 1 CALC, 2 FIX)
//
// Handshake: start/op/a/b form a request that is taken on a rising edge only
// when the unit is IDLE and flush is low; while busy the request is refused
// and stall tells EX to hold the instruction (and its operands) unchanged
// until busy drops.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // {product hi, multiplier} or {remainder, quotient}
  logic               is_div;
  logic               a_neg;     // signed op with negative rs
  logic               b_neg;     // signed op with negative rt
  logic               div_zero;

  logic               sgn_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;
  logic               early_out;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign busy      = (state != S_IDLE);
  assign stall     = busy & (hilo_rd | start);
  assign state_dbg = state;

  // Operand magnitudes: op[0]=0 selects the signed variants.
  always_comb begin
    sgn_op = ~op[0];
    a_mag  = (sgn_op & a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn_op & b[WIDTH-1]) ? -b : b;
  end

  // One iteration of multiply or divide, plus the optional early exit.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // Trial subtract on the upper WIDTH+1 bits after the left shift.
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = {1'b0, div_sh} - {2'b00, opnd};
    if (!div_diff[WIDTH+1]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    acc_next  = is_div ? div_next : mul_next;
    early_out = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    // After this step the low cnt bits still hold unconsumed multiplier bits.
    early_out = !is_div && (cnt != 5'd0) &&
                ((mul_next[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt)) == '0);
`endif
  end

  // Sign fix-up applied in FIX.
  always_comb begin
    prod = (a_neg ^ b_neg) ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // Remainder follows the dividend sign; divide by zero forces all-ones.
      res_hi = a_neg ? -rem : rem;
      res_lo = div_zero ? '1 : ((a_neg ^ b_neg) ? -quo : quo);
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      opnd     <= '0;
      acc      <= '0;
      is_div   <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                is_div   <= op[1];
                opnd     <= op[1] ? b_mag : a_mag;
                acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                a_neg    <= sgn_op & a[WIDTH-1];
                b_neg    <= sgn_op & b[WIDTH-1];
                div_zero <= op[1] & (b == '0);
                cnt      <= 5'd31;
                state    <= S_CALC;
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (early_out) begin
            acc   <= acc_next >> cnt;
            state <= S_FIX;
          end else begin
            acc <= acc_next;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against constants
// from the behaviour description and a small arithmetic reference model.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hilo_rd;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_hilo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .hilo_rd   (hilo_rd),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sp;
    int sx;
    int sy;
    int sq;
    int sr;
    case (o)
      3'b000: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      3'b001: return {32'h0, x} * {32'h0, y};
      3'b010: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sx = $signed(x);
        sy = $signed(y);
        sq = sx / sy;
        sr = sx % sy;
        return {sr, sq};
      end
      3'b011: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] y);
    logic [31:0] m;
    int lat;
    m   = (o == 3'b000 && y[31]) ? -y : y;
    lat = 2;
    for (int i = 0; i < 32; i++) if (m[i]) lat = i + 2;
    if (EARLY && (o == 3'b000 || o == 3'b001)) return lat;
    return 33;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue a MULT/DIV-class op and follow it to completion. With stress set,
  // hilo_rd is raised from the 5th busy cycle and a second start is attempted
  // mid-flight; both must only stall.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] expv, input bit stress);
    int n;
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (stress && n >= 5) begin
        hilo_rd = 1'b1;
        #1;
        check({tag, "_stall_rd"}, 64'(stall), 64'd1);
      end
      if (stress && n == 8) begin
        start = 1'b1; op = 3'b011; a = 32'h1; b = 32'h1;
        #1;
        check({tag, "_stall_start"}, 64'(stall), 64'd1);
      end
      if (stress && n == 10) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(exp_lat(o, y)));
    check({tag, "_done"}, 64'(done), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    check({tag, "_hilo"}, {hi, lo}, e);
    if (stress) check({tag, "_idle_nostall"}, 64'(stall), 64'd0);
    hilo_rd  = 1'b0;
    cur_hilo = e;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Issue an op and flush it flush_at busy cycles later.
  task automatic abort_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int flush_at);
    int nd;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    repeat (flush_at - 1) @(negedge clk);
    check({tag, "_busy_before"}, 64'(busy), 64'd1);
    check({tag, "_state_before"}, 64'(state_dbg), (flush_at == 33) ? 64'd2 : 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_hilo_kept"}, {hi, lo}, cur_hilo);
    nd = 0;
    repeat (40) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    check({tag, "_no_done"}, 64'(nd), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    rst_n = 1'b0; start = 1'b0; op = 3'b0; a = 32'h0; b = 32'h0;
    flush = 1'b0; hilo_rd = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    rst_n = 1'b1;

    // MTHI / MTLO in IDLE: written on the issuing edge, never busy.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hCAFE_F00D;
    @(negedge clk);
    check("mthi_hilo", {hi, lo}, {32'hCAFE_F00D, 32'h0});
    check("mthi_busy", 64'(busy), 64'd0);
    op = 3'b101; a = 32'h5;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_hilo", {hi, lo}, {32'hCAFE_F00D, 32'h5});
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);
    cur_hilo = {32'hCAFE_F00D, 32'h5};

    // flush beats start in IDLE.
    start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    op = 3'b000; a = 32'h3; b = 32'h3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_hilo", {hi, lo}, cur_hilo);

    run_op("mult_rd", 3'b000, 32'h0001_0000, 32'hFFFF_0000, 64'hFFFF_FFFF_0000_0000, 1'b1);
    run_op("mult_neg", 3'b000, 32'hFFFF_FFF9, 32'h3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("multu_one", 3'b001, 32'h1234_5678, 32'h1, 64'h0000_0000_1234_5678, 1'b0);
    run_op("multu_zero", 3'b001, 32'h1234_5678, 32'h0, 64'h0, 1'b0);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("divu_16", 3'b011, 32'hFFFF_FFFF, 32'h10, 64'h0000_000F_0FFF_FFFF, 1'b0);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_op("divu_by0", 3'b011, 32'h0000_1234, 32'h0, 64'h0000_1234_FFFF_FFFF, 1'b0);
    run_op("div_by0", 3'b010, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i == 2) ry = 32'h0;
      if (i == 3) ry = 32'($urandom_range(1, 15));
      run_op("rand", ro, rx, ry, model(ro, rx, ry), 1'b0);
    end

    abort_op("flush_calc", 3'b000, 32'h5, 32'h7, 10);
    abort_op("flush_fix", 3'b011, 32'h64, 32'h7, 33);

    // Reset in the middle of a divide clears everything at once.
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_hilo = 64'h0;

    run_op("divu_after_rst", 3'b011, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS32 core. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. It runs a radix-2 shift-add multiply or restoring divide over 32 cycles. It raises a pipeline stall when HI/LO is read, or a new op is issued, while a computation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; only 32 is supported (the counter is 5 bits).

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  EX issues a muldiv op this cycle
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
b  input  32  rt operand (divisor / multiplier)
flush  input  1  pipeline exception/flush; aborts the in-flight op
hilo_rd  input  1  MFHI/MFLO in EX this cycle
busy  output  1  computation in flight (CALC or FIX)
done  output  1  one-cycle pulse: HI/LO just updated by a MULT/DIV result
stall  output  1  combinational: busy & (hilo_rd | start)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation discards the op.
- States: IDLE, CALC, FIX.
- IDLE:
  - start & op∈{MULT..DIVU} & ~flush → latch |a| and |b|; signed ops take magnitudes, unsigned ops take raw values. Also latch sign flags, op, count=31; go to CALC.
  - start & op=MTHI → hi<=a, same edge. start & op=MTLO → lo<=a, same edge. Stay IDLE.
- CALC: one iteration per cycle, 32 cycles; count decrements; leave for FIX when count==0.
  - Multiply: 64-bit product accumulator; add the multiplicand when the current multiplier LSB=1, then shift right.
  - Divide: 64-bit remainder/quotient shift register; trial subtract of the divisor from the upper 33 bits; a quotient bit of 1 keeps the difference.
- FIX (1 cycle) → IDLE:
  - Signed MULT with differing operand signs: negate the 64-bit product.
  - Signed DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Write hi=upper/remainder and lo=lower/quotient; done=1 during the following cycle.
- Timing: start sampled at edge E0; busy=1 from E0 to E33 (33 cycles); hi/lo new at E33; earliest next start accepted at E34.
- Divide by zero (b=0, DIV or DIVU): no trap; result hi=a (original), lo=0xFFFFFFFF, with normal 33-cycle latency.
- 0x80000000 / -1 (DIV): lo=0x80000000, hi=0 (falls out of magnitude arithmetic).
- start while busy: not accepted; stall=1 holds the issuing instruction in EX until IDLE. MTHI/MTLO while busy are likewise stalled.
- hilo_rd while busy: stall=1. In IDLE, hi/lo are read directly; there is no forwarding of same-edge MTHI/MTLO (the next cycle sees the new value).
- flush:
  - In CALC/FIX: next edge returns to IDLE; hi/lo unchanged; done not pulsed.
  - In IDLE together with start: flush wins; nothing is latched or written.
- done is never asserted for MTHI/MTLO or aborted ops.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- When defined: during a MULT/MULTU in CALC, if the remaining unshifted multiplier bits are all zero, shift the accumulator into its final position and move to FIX on the next edge. Multiply latency becomes (index of highest set multiplier bit + 2) cycles; a zero multiplier takes 2 cycles. Divide is unaffected.
- When undefined: fixed 33-cycle latency for all ops.

Test Plan:
- MULT a=0xFFFFFFF9 (-7), b=3 → after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse 1 cycle.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. With MULDIV_EARLY_OUT_EN, MULTU b=1 completes in 2 cycles with lo=a.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0xFFFFFFFF, b=16 → lo=0x0FFFFFFF, hi=0xF. DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → hi=0x1234, lo=0xFFFFFFFF.
- MTHI 0xCAFEF00D then MTLO 0x5 in IDLE → hi/lo update on the same edges, no busy. Then MULT issued with hilo_rd high at cycle 5 → stall=1 until busy falls, hi/lo new at E33.
- MULT started, flush at cycle 10 → IDLE next edge, hi/lo retain the prior values, no done. rst_n low at cycle 20 of a DIV → all outputs 0 immediately.
